// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, latched request.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int RD_LAT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPT,
        ST_WRITE,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] wdata;
    } req_t;

    // Size 2'b11 behaves as a word everywhere.
    function automatic logic is_sub(input logic [1:0] size);
        return !size[1];
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] ldata,
    output logic [31:0] merged
);

    logic [7:0]  lb;
    logic [15:0] lh;

    always_comb begin
        lb = rword[{off, 3'b000} +: 8];
        lh = off[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_BYTE: ldata = {{24{lb[7] & ~uns}}, lb};
            SZ_HALF: ldata = {{16{lh[15] & ~uns}}, lh};
            default: ldata = rword;
        endcase
    end

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{off, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (off[1]) merged[31:16] = wdata[15:0];
                else        merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: sequences multi-cycle reads, read-modify-write for sub-word
// stores, and returns extended load data with a misalignment flag.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int MEM_AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);

    localparam int            CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);

    state_t        state, state_nxt;
    req_t          r;
    logic [CW-1:0] cnt;
    logic [31:0]   ldata, merged;
    logic          req_mis;
    logic          unused_addr_hi;

    // Upper address bits alias away by construction.
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

    assign req_mis   = misaligned(req_size, req_addr[1:0]);
    assign req_ready = (state == ST_IDLE) && !reset;
    assign mem_rd    = (state == ST_READ);
    assign mem_wr    = (state == ST_WRITE);

    lsu_lane_align u_align (
        .rword    (mem_rdata),
        .old_word (mem_rdata),
        .wdata    (r.wdata),
        .off      (r.off),
        .size     (r.size),
        .uns      (r.uns),
        .ldata    (ldata),
        .merged   (merged)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_mis)                         state_nxt = ST_RESP;
                    else if (req_we && !is_sub(req_size)) state_nxt = ST_WRITE;
                    else                                 state_nxt = ST_READ;
                end
            end
            ST_READ:  if (cnt == '0) state_nxt = ST_CAPT;
            ST_CAPT:  state_nxt = r.we ? ST_WRITE : ST_RESP;
            ST_WRITE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            r          <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            resp_valid <= (state_nxt == ST_RESP);
            // Only a misaligned request jumps straight from IDLE to RESP.
            resp_err   <= (state == ST_IDLE) && (state_nxt == ST_RESP);
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r.we      <= req_we;
                        r.size    <= req_size;
                        r.uns     <= req_unsigned;
                        r.off     <= req_addr[1:0];
                        r.wdata   <= req_wdata;
                        cnt       <= CNT_INIT;
                        mem_addr  <= {{(32-MEM_AW){1'b0}}, req_addr[MEM_AW+1:2]};
                        mem_wdata <= req_wdata;
                    end
                end
                ST_READ: cnt <= cnt - 1'b1;
                ST_CAPT: begin
                    if (r.we) mem_wdata  <= merged;
                    else      resp_rdata <= ldata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed table, abort and back-to-back sequences, and random
// traffic checked against a word-array memory model.
module tb_lsu_ctrl;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_we = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, resp_valid, resp_err, mem_rd, mem_wr;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        req_valid_1 = 0, req_we_1 = 0, req_unsigned_1 = 0;
    logic [1:0]  req_size_1 = 0;
    logic [31:0] req_addr_1 = 0, req_wdata_1 = 0;
    logic        req_ready_1, resp_valid_1, resp_err_1, mem_rd_1, mem_wr_1;
    logic [31:0] resp_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;

    lsu_ctrl #(.RD_LAT(L), .MEM_AW(10)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    lsu_ctrl #(.RD_LAT(1), .MEM_AW(10)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid_1), .req_ready(req_ready_1),
        .req_we(req_we_1), .req_size(req_size_1), .req_unsigned(req_unsigned_1),
        .req_addr(req_addr_1), .req_wdata(req_wdata_1), .resp_valid(resp_valid_1),
        .resp_err(resp_err_1), .resp_rdata(resp_rdata_1), .mem_addr(mem_addr_1),
        .mem_wdata(mem_wdata_1), .mem_rd(mem_rd_1), .mem_wr(mem_wr_1), .mem_rdata(mem_rdata_1)
    );

    // Data memories: combinational read of the held index, write on mem_wr.
    logic [31:0] mem  [0:1023];
    logic [31:0] mem1 [0:1023];
    always @(posedge clk) if (mem_wr) mem[mem_addr[9:0]] <= mem_wdata;
    always @(posedge clk) if (mem_wr_1) mem1[mem_addr_1[9:0]] <= mem_wdata_1;
    assign mem_rdata   = mem[mem_addr[9:0]];
    assign mem_rdata_1 = mem1[mem_addr_1[9:0]];

    // Reference model state.
    logic [31:0] ref_mem [0:1023];
    logic [31:0] last_rd = 0;

    int n_chk = 0, n_pass = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    function automatic bit m_mis(input logic [1:0] sz, input int unsigned a);
        if (sz == 2'd0) return 0;
        if (sz == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input int unsigned a,
                                           input logic [1:0] sz, input logic uns);
        int unsigned v;
        if (sz == 2'd0) begin
            v = (w >> ((a % 4) * 8)) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (w >> (((a / 2) % 2) * 16)) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else v = w;
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] wd,
                                            input int unsigned a, input logic [1:0] sz);
        int unsigned mask, sh;
        mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        sh   = (sz == 2'd0) ? (a % 4) * 8 : ((a / 2) % 2) * 16;
        return (w & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic do_req(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got, output logic got_err);
        int          rc, wi, exp_rc;
        logic [31:0] rdm, wrm, exp_rdm, exp_wrm, wdat, nw;
        logic        addr_bad, err;
        bit          mis, sub;
        mis = m_mis(sz, a);
        sub = (sz < 2);
        wi  = (a / 4) % 1024;
        rc = 0; rdm = 0; wrm = 0; wdat = 0; addr_bad = 0; err = 0; got = 0;
        @(negedge clk);
        chk({nm, "_ready"}, req_ready, 1);
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 0;
            if (mem_rd) rdm[c] = 1'b1;
            if (mem_wr) begin wrm[c] = 1'b1; wdat = mem_wdata; end
            if ((mem_rd || mem_wr) && mem_addr != 32'(wi)) addr_bad = 1;
            if (resp_valid) begin rc = c; err = resp_err; got = resp_rdata; break; end
        end
        got_err = err;
        exp_rc  = mis ? 1 : (we && !sub) ? 2 : !we ? L + 2 : L + 3;
        exp_rdm = (mis || (we && !sub)) ? 32'h0 : 32'(((1 << L) - 1) << 1);
        exp_wrm = (mis || !we) ? 32'h0 : sub ? 32'(1 << (L + 2)) : 32'h2;
        chk({nm, "_resp_cycle"}, rc, exp_rc);
        chk({nm, "_rd_cycles"}, rdm, exp_rdm);
        chk({nm, "_wr_cycles"}, wrm, exp_wrm);
        chk({nm, "_addr"}, addr_bad, 0);
        chk({nm, "_err"}, err, mis);
        if (!mis && !we) last_rd = m_load(ref_mem[wi], a, sz, uns);
        if (!mis && we) begin
            nw = sub ? m_merge(ref_mem[wi], wd, a, sz) : wd;
            chk({nm, "_wdata"}, wdat, nw);
            ref_mem[wi] = nw;
        end
        chk({nm, "_rdata"}, got, last_rd);
        @(negedge clk);
        chk({nm, "_pulse"}, {resp_valid, req_ready}, 2'b01);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [15];
    logic [31:0] got;
    logic        got_err;
    logic        saw;

    initial begin
        tbl[0]  = '{1, 2'd2, 0, 32'h10,   32'hDEADBEEF, 0, 32'h0,        0};
        tbl[1]  = '{0, 2'd2, 0, 32'h10,   32'h0,        1, 32'hDEADBEEF, 0};
        tbl[2]  = '{1, 2'd2, 0, 32'h10,   32'h80FF1234, 0, 32'h0,        0};
        tbl[3]  = '{0, 2'd0, 0, 32'h13,   32'h0,        1, 32'hFFFFFF80, 0};
        tbl[4]  = '{0, 2'd0, 1, 32'h13,   32'h0,        1, 32'h00000080, 0};
        tbl[5]  = '{0, 2'd1, 0, 32'h10,   32'h0,        1, 32'h00001234, 0};
        tbl[6]  = '{0, 2'd1, 0, 32'h12,   32'h0,        1, 32'hFFFF80FF, 0};
        tbl[7]  = '{0, 2'd1, 1, 32'h12,   32'h0,        1, 32'h000080FF, 0};
        tbl[8]  = '{1, 2'd2, 0, 32'h20,   32'h11223344, 0, 32'h0,        0};
        tbl[9]  = '{1, 2'd1, 0, 32'h22,   32'h5555ABCD, 0, 32'h0,        0};
        tbl[10] = '{0, 2'd2, 0, 32'h20,   32'h0,        1, 32'hABCD3344, 0};
        tbl[11] = '{0, 2'd2, 0, 32'h06,   32'h0,        0, 32'h0,        1};
        tbl[12] = '{1, 2'd1, 0, 32'h11,   32'h0000BEEF, 0, 32'h0,        1};
        tbl[13] = '{0, 2'd2, 0, 32'h10,   32'h0,        1, 32'h80FF1234, 0};
        tbl[14] = '{0, 2'd3, 0, 32'h1010, 32'h0,        1, 32'h80FF1234, 0};

        // Reset state
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_resp", {resp_valid, resp_err}, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_mwdata", mem_wdata, 0);
        chk("rst_mem_en", {mem_rd, mem_wr, mem_rd_1, mem_wr_1}, 0);
        reset = 0;

        for (int i = 0; i < 16; i++)
            do_req($sformatf("fill%0d", i), 1, 2'd2, 0, 32'(i * 4), $urandom, got, got_err);

        for (int i = 0; i < 15; i++) begin
            do_req($sformatf("t%0d", i), tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr,
                   tbl[i].wdata, got, got_err);
            chk($sformatf("t%0d_tbl_err", i), got_err, tbl[i].exp_err);
            if (tbl[i].chk_rd) chk($sformatf("t%0d_tbl_rdata", i), got, tbl[i].exp_rd);
        end

        // Abort a byte store to 0x20 while its read is in flight.
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'd0; req_unsigned = 0;
        req_addr = 32'h20; req_wdata = 32'h77;
        @(negedge clk);
        req_valid = 0;
        chk("abort_rd_before", mem_rd, 1);
        reset = 1;
        #1;
        chk("abort_rd_drop", {mem_rd, req_ready}, 0);
        saw = 0;
        repeat (2) begin @(negedge clk); saw |= mem_wr | resp_valid; end
        reset = 0;
        last_rd = 0;
        repeat (3) begin @(negedge clk); saw |= mem_wr | resp_valid; end
        chk("abort_no_wr_resp", saw, 0);
        chk("abort_ready_after", req_ready, 1);
        do_req("abort_chk", 0, 2'd2, 0, 32'h20, 0, got, got_err);
        chk("abort_mem_kept", got, 32'hABCD3344);

        for (int i = 0; i < 200; i++)
            do_req($sformatf("r%0d", i), 1'($urandom), 2'($urandom), 1'($urandom),
                   ($urandom & 32'hFFFFF000) | $urandom_range(0, 63), $urandom, got, got_err);

        // RD_LAT=1 instance: store, then held-high back-to-back loads.
        @(negedge clk);
        req_valid_1 = 1; req_we_1 = 1; req_size_1 = 2'd2; req_addr_1 = 32'h08;
        req_wdata_1 = 32'hCAFEF00D;
        @(negedge clk);
        req_valid_1 = 0;
        chk("b2b_store_wr", mem_wr_1, 1);
        repeat (2) @(negedge clk);
        req_valid_1 = 1; req_we_1 = 0; req_unsigned_1 = 0;
        chk("b2b_ready0", req_ready_1, 1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_c%0d", c), {req_ready_1, resp_valid_1, mem_rd_1},
                {c == 4, c == 3 || c == 7, c == 1 || c == 5});
            if (c == 3 || c == 7) chk($sformatf("b2b_data%0d", c), resp_rdata_1, 32'hCAFEF00D);
        end
        req_valid_1 = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
